// File: rtl/round_key_store_pkg.sv
// Shared constants and state encoding for the round-key buffer between
// the key schedule and the cipher round core.
package round_key_store_pkg;

    localparam int KEY_W    = 128;
    localparam int NUM_KEYS = 10;
    localparam int IDX_W    = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        READY,
        READ
    } state_t;

endpackage

// File: rtl/round_key_ram.sv
// Round-key register file: one synchronous write port, one combinational
// read port. Contents are deliberately not reset.
module round_key_ram
    import round_key_store_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [KEY_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [KEY_W-1:0] rdata
);

    logic [KEY_W-1:0] mem [NUM_KEYS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/round_key_store.sv
// Buffers one key schedule's worth of round keys and replays them in
// forward (encrypt) or reverse (decrypt) order, any number of times.
module round_key_store
    import round_key_store_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start,
    input  logic             wr_valid,
    input  logic [KEY_W-1:0] wr_key,
    output logic             wr_ready,
    input  logic             encrypt,
    input  logic             rd_start,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [KEY_W-1:0] rd_key,
    output logic [IDX_W-1:0] rd_index,
    output logic             rd_last,
    output logic             keys_loaded,
    output logic             busy
);

    state_t           state, state_next;
    logic [IDX_W-1:0] wr_ptr, wr_ptr_next;
    logic [IDX_W-1:0] rd_ptr, rd_ptr_next;
    logic             dir, dir_next;
    logic             we;
    logic [KEY_W-1:0] ram_rdata;
    logic             rd_last_next;

    round_key_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (wr_key),
        .raddr (rd_ptr_next),
        .rdata (ram_rdata)
    );

    // load_start overrides everything, including a read pass in flight
    always_comb begin
        state_next  = state;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        dir_next    = dir;
        we          = 1'b0;
        if (load_start) begin
            state_next  = LOAD;
            wr_ptr_next = '0;
        end else begin
            case (state)
                EMPTY: ;
                LOAD: begin
                    if (wr_valid) begin
                        we = 1'b1;
                        if (wr_ptr == LAST_IDX) begin
                            state_next = READY;
                        end else begin
                            wr_ptr_next = wr_ptr + 1'b1;
                        end
                    end
                end
                READY: begin
                    if (rd_start) begin
                        state_next  = READ;
                        dir_next    = encrypt;
                        rd_ptr_next = encrypt ? '0 : LAST_IDX;
                    end
                end
                READ: begin
                    if (rd_valid && rd_ready) begin
                        if (rd_last) begin
                            state_next = READY;
                        end else if (dir) begin
                            rd_ptr_next = rd_ptr + 1'b1;
                        end else begin
                            rd_ptr_next = rd_ptr - 1'b1;
                        end
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    assign rd_last_next = (state_next == READ) &&
                          (dir_next ? (rd_ptr_next == LAST_IDX) : (rd_ptr_next == '0));

    // Outputs are registered from next-state so they line up with the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= EMPTY;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            dir         <= 1'b0;
            wr_ready    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_key      <= '0;
            rd_index    <= '0;
            rd_last     <= 1'b0;
            keys_loaded <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            dir         <= dir_next;
            wr_ready    <= (state_next == LOAD);
            rd_valid    <= (state_next == READ);
            keys_loaded <= (state_next == READY) || (state_next == READ);
            busy        <= (state_next == LOAD) || (state_next == READ);
            rd_last     <= rd_last_next;
            if (state_next == READ) begin
                rd_key   <= ram_rdata;
                rd_index <= rd_ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store: loads, encrypt/decrypt passes,
// backpressure, mid-read reload and asynchronous reset, scoreboard-checked.
module tb_round_key_store;
    import round_key_store_pkg::*;

    logic             clk;
    logic             reset;
    logic             load_start;
    logic             wr_valid;
    logic [KEY_W-1:0] wr_key;
    logic             wr_ready;
    logic             encrypt;
    logic             rd_start;
    logic             rd_valid;
    logic             rd_ready;
    logic [KEY_W-1:0] rd_key;
    logic [IDX_W-1:0] rd_index;
    logic             rd_last;
    logic             keys_loaded;
    logic             busy;

    typedef struct {
        logic [KEY_W-1:0] key;
        logic [IDX_W-1:0] index;
        logic             last;
    } exp_t;

    exp_t             sb_queue [$];
    logic [KEY_W-1:0] key_model [NUM_KEYS];
    int               assert_count = 0;
    int               fail_count   = 0;

    round_key_store dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .wr_valid    (wr_valid),
        .wr_key      (wr_key),
        .wr_ready    (wr_ready),
        .encrypt     (encrypt),
        .rd_start    (rd_start),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_key      (rd_key),
        .rd_index    (rd_index),
        .rd_last     (rd_last),
        .keys_loaded (keys_loaded),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [KEY_W-1:0] observed,
                               input logic [KEY_W-1:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; the DUT samples them at the next rising edge
    task automatic applyStimulus(input logic ls, input logic wv, input logic [KEY_W-1:0] wk,
                                 input logic rs, input logic enc, input logic rr);
        load_start = ls;
        wr_valid   = wv;
        wr_key     = wk;
        rd_start   = rs;
        encrypt    = enc;
        rd_ready   = rr;
        @(negedge clk);
    endtask

    task automatic checkResetValues(input string phase);
        checkOutput({phase, "_wr_ready"},    wr_ready,    0);
        checkOutput({phase, "_rd_valid"},    rd_valid,    0);
        checkOutput({phase, "_rd_key"},      rd_key,      0);
        checkOutput({phase, "_rd_index"},    rd_index,    0);
        checkOutput({phase, "_rd_last"},     rd_last,     0);
        checkOutput({phase, "_keys_loaded"}, keys_loaded, 0);
        checkOutput({phase, "_busy"},        busy,        0);
    endtask

    task automatic doLoad(input bit poke_read);
        applyStimulus(1, 0, '0, 0, 0, 0);
        checkOutput("load_wr_ready",    wr_ready,    1);
        checkOutput("load_rd_valid",    rd_valid,    0);
        checkOutput("load_keys_loaded", keys_loaded, 0);
        checkOutput("load_busy",        busy,        1);
        for (int i = 0; i < NUM_KEYS; i++) begin
            checkOutput($sformatf("wr_ready_before_write%0d", i), wr_ready, 1);
            checkOutput($sformatf("keys_loaded_before_write%0d", i), keys_loaded, 0);
            applyStimulus(0, 1, key_model[i], poke_read, 1, 1);
            if (poke_read) checkOutput($sformatf("early_rd_valid%0d", i), rd_valid, 0);
        end
        checkOutput("loaded_wr_ready",    wr_ready,    0);
        checkOutput("loaded_keys_loaded", keys_loaded, 1);
        applyStimulus(0, 0, '0, 0, 0, 0);
        checkOutput("idle_busy",        busy,        0);
        checkOutput("idle_keys_loaded", keys_loaded, 1);
        checkOutput("idle_rd_valid",    rd_valid,    0);
    endtask

    // Expected keys enter the scoreboard when rd_start is driven; entries leave on handshakes
    task automatic readPass(input logic enc, input bit toggle, input int max_pops);
        int   pops;
        exp_t e;
        for (int k = 0; k < NUM_KEYS; k++) begin
            e.index = enc ? IDX_W'(k) : IDX_W'(NUM_KEYS - 1 - k);
            e.key   = key_model[e.index];
            e.last  = (k == NUM_KEYS - 1);
            sb_queue.push_back(e);
        end
        applyStimulus(0, 0, '0, 1, enc, 1);
        rd_start = 1'b0;
        pops = 0;
        for (int cyc = 0; cyc < 4 * NUM_KEYS && pops < max_pops; cyc++) begin
            rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            encrypt  = ~enc;
            checkOutput("rd_valid_in_pass", rd_valid, 1);
            checkOutput("rd_key",   rd_key,   sb_queue[0].key);
            checkOutput("rd_index", rd_index, sb_queue[0].index);
            checkOutput("rd_last",  rd_last,  sb_queue[0].last);
            if (rd_ready) begin
                void'(sb_queue.pop_front());
                pops++;
            end
            @(negedge clk);
        end
        checkOutput("read_handshakes", pops, max_pops);
        if (max_pops == NUM_KEYS) begin
            checkOutput("rd_valid_after_last", rd_valid, 0);
            checkOutput("keys_loaded_after_pass", keys_loaded, 1);
        end
        sb_queue.delete();
    endtask

    initial begin
        logic [3:0] nib;
        reset = 1'b0;
        load_start = 0; wr_valid = 0; wr_key = '0; rd_start = 0; encrypt = 0; rd_ready = 0;
        @(negedge clk);
        checkResetValues("reset");
        reset = 1'b1;
        @(negedge clk);

        applyStimulus(0, 1, '1, 1, 1, 1);
        checkOutput("empty_rd_valid", rd_valid, 0);
        checkOutput("empty_busy",     busy,     0);
        checkOutput("empty_wr_ready", wr_ready, 0);

        for (int i = 0; i < NUM_KEYS; i++) begin
            nib = 4'(i);
            key_model[i] = {32{nib}};
        end
        $display("[TB] load K and run encrypt/decrypt passes");
        doLoad(0);
        readPass(1, 0, NUM_KEYS);
        readPass(0, 0, NUM_KEYS);
        readPass(0, 0, NUM_KEYS);
        readPass(1, 1, NUM_KEYS);

        $display("[TB] reload during a read pass");
        readPass(1, 0, 3);
        for (int i = 0; i < NUM_KEYS; i++) key_model[i] = ~key_model[i];
        doLoad(0);
        readPass(0, 0, NUM_KEYS);

        $display("[TB] asynchronous reset during a load");
        applyStimulus(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, {4{$urandom}}, 0, 0, 1);
        reset = 1'b0;
        #1;
        checkResetValues("async_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NUM_KEYS; i++) key_model[i] = {$urandom, $urandom, $urandom, $urandom};
        doLoad(1);
        readPass(0, 0, NUM_KEYS);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
